// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage : execute stage (ALU, flags, signed multiply, writeback register)
// Build option EX_FAST_MUL_EN: single-cycle combinational IMUL.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ex_stage #(
  parameter int XLEN = 64,
  parameter int OPW  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_nop,
  input  logic [OPW-1:0]  in_oper,
  input  logic [XLEN-1:0] in_oper1,
  input  logic [XLEN-1:0] in_oper2,
  input  logic [3:0]      in_dstreg,
  input  logic [1:0]      in_size,
  input  logic            in_flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_wb_en,
  output logic [3:0]      out_dstreg,
  output logic [XLEN-1:0] out_result,
  output logic [3:0]      out_flags,
  output logic            out_illegal
);

  localparam logic [OPW-1:0] c_op_add  = 8'h01;
  localparam logic [OPW-1:0] c_op_sub  = 8'h02;
  localparam logic [OPW-1:0] c_op_and  = 8'h03;
  localparam logic [OPW-1:0] c_op_or   = 8'h04;
  localparam logic [OPW-1:0] c_op_xor  = 8'h05;
  localparam logic [OPW-1:0] c_op_mov  = 8'h06;
  localparam logic [OPW-1:0] c_op_cmp  = 8'h07;
  localparam logic [OPW-1:0] c_op_shl  = 8'h08;
  localparam logic [OPW-1:0] c_op_shr  = 8'h09;
  localparam logic [OPW-1:0] c_op_imul = 8'h0A;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUSY = 1'b1} state_e;

  function automatic logic [63:0] f_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   f_mask = 64'h0000_0000_0000_00FF;
      2'b01:   f_mask = 64'h0000_0000_0000_FFFF;
      2'b10:   f_mask = 64'h0000_0000_FFFF_FFFF;
      default: f_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  function automatic logic f_msb(input logic [63:0] v, input logic [1:0] sz);
    case (sz)
      2'b00:   f_msb = v[7];
      2'b01:   f_msb = v[15];
      2'b10:   f_msb = v[31];
      default: f_msb = v[63];
    endcase
  endfunction

  function automatic logic [63:0] f_sext(input logic [63:0] v, input logic [1:0] sz);
    case (sz)
      2'b00:   f_sext = {{56{v[7]}}, v[7:0]};
      2'b01:   f_sext = {{48{v[15]}}, v[15:0]};
      2'b10:   f_sext = {{32{v[31]}}, v[31:0]};
      default: f_sext = v;
    endcase
  endfunction

  // Narrow writes keep the upper register bits; 32-bit writes zero-extend.
  function automatic logic [63:0] f_merge(input logic [63:0] o1, input logic [63:0] r,
                                          input logic [1:0] sz);
    case (sz)
      2'b00:   f_merge = {o1[63:8], r[7:0]};
      2'b01:   f_merge = {o1[63:16], r[15:0]};
      2'b10:   f_merge = {32'd0, r[31:0]};
      default: f_merge = r;
    endcase
  endfunction

  function automatic logic [6:0] f_width(input logic [1:0] sz);
    case (sz)
      2'b00:   f_width = 7'd8;
      2'b01:   f_width = 7'd16;
      2'b10:   f_width = 7'd32;
      default: f_width = 7'd64;
    endcase
  endfunction

  // Returns {OF,SF,ZF,CF, merged result} for a full 2W-bit signed product.
  function automatic logic [67:0] f_mul_pack(input logic [127:0] p, input logic [1:0] sz,
                                             input logic [63:0] o1);
    logic [63:0] r;
    logic [63:0] rs;
    logic        ovf;
    r   = p[63:0] & f_mask(sz);
    rs  = f_sext(r, sz);
    ovf = (p != {{64{rs[63]}}, rs});
    f_mul_pack = {ovf, f_msb(r, sz), (r == 64'd0), ovf, f_merge(o1, r, sz)};
  endfunction

  state_e      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        out_valid_q, out_valid_d;
  logic        out_wb_en_q;
  logic [3:0]  out_dstreg_q;
  logic [63:0] out_result_q;
  logic [3:0]  out_flags_q;
  logic        out_illegal_q;

  logic        w_accept;
  logic        w_in_ready;
  logic [63:0] w_mask;
  logic [63:0] w_a, w_b, w_r;
  logic [63:0] w_sa, w_sb;
  logic [64:0] w_sum;
  logic [6:0]  w_width, w_cnt;
  logic [5:0]  w_idx;
  logic        w_cf, w_of, w_upd, w_raw, w_is_mul;
  logic [63:0] w_ex_res;
  logic [3:0]  w_ex_flags;
  logic        w_ex_wb, w_ex_ill;

  logic        w_load, w_mul_start, w_mul_step;
  logic [63:0] w_ld_res;
  logic [3:0]  w_ld_flags;
  logic        w_ld_wb, w_ld_ill;
  logic [3:0]  w_ld_dst;

  assign w_in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready) && !in_flush;
  assign w_accept   = in_valid && w_in_ready;

  assign w_mask  = f_mask(in_size);
  assign w_width = f_width(in_size);
  assign w_sa    = f_sext(in_oper1, in_size);
  assign w_sb    = f_sext(in_oper2, in_size);
  assign w_cnt   = (in_size == 2'b11) ? {1'b0, in_oper2[5:0]} : {2'b00, in_oper2[4:0]};

`ifdef EX_FAST_MUL_EN
  logic [127:0] w_fast_prod;
  logic [67:0]  w_fast_pack;
  assign w_fast_prod = {{64{w_sa[63]}}, w_sa} * {{64{w_sb[63]}}, w_sb};
  assign w_fast_pack = f_mul_pack(w_fast_prod, in_size, in_oper1);
`else
  logic [127:0] mcand_q;
  logic [63:0]  mplier_q;
  logic [127:0] prod_q;
  logic         neg_q;
  logic [1:0]   m_size_q;
  logic [63:0]  m_oper1_q;
  logic [3:0]   m_dst_q;
  logic [127:0] w_prod_step, w_prod_fin;
  logic [67:0]  w_mul_pack;

  assign w_prod_step = prod_q + (mplier_q[0] ? mcand_q : 128'd0);
  assign w_prod_fin  = neg_q ? (128'd0 - w_prod_step) : w_prod_step;
  assign w_mul_pack  = f_mul_pack(w_prod_fin, m_size_q, m_oper1_q);

  // Shift-add on magnitudes; sign is reapplied once the last bit is folded in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      prod_q    <= '0;
      neg_q     <= 1'b0;
      m_size_q  <= '0;
      m_oper1_q <= '0;
      m_dst_q   <= '0;
    end else if (w_mul_start) begin
      mcand_q   <= {64'd0, (w_sa[63] ? (64'd0 - w_sa) : w_sa)};
      mplier_q  <= w_sb[63] ? (64'd0 - w_sb) : w_sb;
      prod_q    <= '0;
      neg_q     <= w_sa[63] ^ w_sb[63];
      m_size_q  <= in_size;
      m_oper1_q <= in_oper1;
      m_dst_q   <= in_dstreg;
    end else if (w_mul_step) begin
      prod_q   <= w_prod_step;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end
`endif

  always_comb begin
    w_a        = in_oper1 & w_mask;
    w_b        = in_oper2 & w_mask;
    w_r        = '0;
    w_sum      = '0;
    w_idx      = '0;
    w_cf       = 1'b0;
    w_of       = 1'b0;
    w_upd      = 1'b0;
    w_raw      = 1'b0;
    w_is_mul   = 1'b0;
    w_ex_wb    = 1'b1;
    w_ex_ill   = 1'b0;
    w_ex_flags = out_flags_q;
    case (in_oper)
      c_op_add: begin
        w_sum = {1'b0, w_a} + {1'b0, w_b};
        w_r   = w_sum[63:0] & w_mask;
        w_cf  = |(w_sum & {1'b1, ~w_mask});
        w_of  = (f_msb(w_a, in_size) == f_msb(w_b, in_size)) &&
                (f_msb(w_r, in_size) != f_msb(w_a, in_size));
        w_upd = 1'b1;
      end
      c_op_sub, c_op_cmp: begin
        w_r   = (w_a - w_b) & w_mask;
        w_cf  = (w_a < w_b);
        w_of  = (f_msb(w_a, in_size) != f_msb(w_b, in_size)) &&
                (f_msb(w_r, in_size) != f_msb(w_a, in_size));
        w_upd = 1'b1;
        if (in_oper == c_op_cmp) begin
          w_ex_wb = 1'b0;
          w_raw   = 1'b1;
        end
      end
      c_op_and: begin w_r = w_a & w_b; w_upd = 1'b1; end
      c_op_or:  begin w_r = w_a | w_b; w_upd = 1'b1; end
      c_op_xor: begin w_r = w_a ^ w_b; w_upd = 1'b1; end
      c_op_mov: w_r = w_b;
      c_op_shl, c_op_shr: begin
        if (w_cnt == 7'd0) begin
          w_r = w_a;
        end else if (w_cnt >= w_width) begin
          w_r   = '0;
          w_upd = 1'b1;
        end else if (in_oper == c_op_shl) begin
          w_idx = w_width[5:0] - w_cnt[5:0];
          w_r   = (w_a << w_cnt) & w_mask;
          w_cf  = w_a[w_idx];
          w_upd = 1'b1;
        end else begin
          w_idx = w_cnt[5:0] - 6'd1;
          w_r   = w_a >> w_cnt;
          w_cf  = w_a[w_idx];
          w_upd = 1'b1;
        end
      end
      c_op_imul: begin
`ifdef EX_FAST_MUL_EN
        w_is_mul = 1'b0;
`else
        w_is_mul = 1'b1;
`endif
      end
      default: begin
        w_ex_ill = 1'b1;
        w_ex_wb  = 1'b0;
        w_raw    = 1'b1;
      end
    endcase
    w_ex_res = w_raw ? in_oper1 : f_merge(in_oper1, w_r, in_size);
    if (w_upd) begin
      w_ex_flags = {w_of, f_msb(w_r, in_size), (w_r == 64'd0), w_cf};
    end
`ifdef EX_FAST_MUL_EN
    if (in_oper == c_op_imul) begin
      {w_ex_flags, w_ex_res} = w_fast_pack;
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    w_load      = 1'b0;
    w_mul_start = 1'b0;
    w_mul_step  = 1'b0;
    w_ld_res    = w_ex_res;
    w_ld_flags  = w_ex_flags;
    w_ld_wb     = w_ex_wb;
    w_ld_ill    = w_ex_ill;
    w_ld_dst    = in_dstreg;
    case (state_q)
      S_IDLE: begin
        if (w_accept && !in_nop) begin
          if (w_is_mul) begin
            state_d     = S_BUSY;
            cnt_d       = w_width;
            w_mul_start = 1'b1;
          end else begin
            w_load = 1'b1;
          end
        end
      end
      S_BUSY: begin
`ifdef EX_FAST_MUL_EN
        state_d = S_IDLE;
`else
        if (in_flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          w_mul_step = 1'b1;
          cnt_d      = cnt_q - 7'd1;
          if (cnt_q == 7'd1) begin
            state_d                = S_IDLE;
            w_load                 = 1'b1;
            {w_ld_flags, w_ld_res} = w_mul_pack;
            w_ld_wb                = 1'b1;
            w_ld_ill               = 1'b0;
            w_ld_dst               = m_dst_q;
          end
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase

    if (in_flush)         out_valid_d = 1'b0;
    else if (w_load)      out_valid_d = 1'b1;
    else if (out_ready)   out_valid_d = 1'b0;
    else                  out_valid_d = out_valid_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      out_valid_q   <= 1'b0;
      out_wb_en_q   <= 1'b0;
      out_dstreg_q  <= '0;
      out_result_q  <= '0;
      out_flags_q   <= '0;
      out_illegal_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      if (w_load) begin
        out_wb_en_q   <= w_ld_wb;
        out_dstreg_q  <= w_ld_dst;
        out_result_q  <= w_ld_res;
        out_flags_q   <= w_ld_flags;
        out_illegal_q <= w_ld_ill;
      end
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = out_valid_q;
  assign out_wb_en   = out_wb_en_q;
  assign out_dstreg  = out_dstreg_q;
  assign out_result  = out_result_q;
  assign out_flags   = out_flags_q;
  assign out_illegal = out_illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_stage : directed vectors with a queue-based writeback scoreboard. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_nop, in_flush;
  logic [7:0]  in_oper;
  logic [63:0] in_oper1, in_oper2;
  logic [3:0]  in_dstreg;
  logic [1:0]  in_size;
  logic        out_valid, out_ready, out_wb_en, out_illegal;
  logic [3:0]  out_dstreg, out_flags;
  logic [63:0] out_result;

  always #5 clk = ~clk;

  ex_stage #(.XLEN(64), .OPW(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_nop(in_nop),
    .in_oper(in_oper), .in_oper1(in_oper1), .in_oper2(in_oper2),
    .in_dstreg(in_dstreg), .in_size(in_size), .in_flush(in_flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_wb_en(out_wb_en),
    .out_dstreg(out_dstreg), .out_result(out_result), .out_flags(out_flags),
    .out_illegal(out_illegal)
  );

  typedef struct {
    int          id;
    logic [63:0] res;
    logic [3:0]  flags;
    logic        wb;
    logic        ill;
    logic [3:0]  dst;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pkt_id   = 0;
  int   cyc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  task automatic push_exp(input logic [63:0] er, input logic [3:0] ef, input logic ewb,
                          input logic eill, input logic [3:0] dst);
    exp_t e;
    e.id = pkt_id; e.res = er; e.flags = ef; e.wb = ewb; e.ill = eill; e.dst = dst;
    q.push_back(e);
    pkt_id++;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [7:0] op, input logic [63:0] o1, input logic [63:0] o2,
                      input logic [3:0] dst, input logic [1:0] sz, input logic nop,
                      input logic push, input logic [63:0] er, input logic [3:0] ef,
                      input logic ewb, input logic eill);
    int n;
    in_valid = 1'b1; in_nop = nop; in_oper = op; in_oper1 = o1; in_oper2 = o2;
    in_dstreg = dst; in_size = sz;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) break;
    end
    if (n > 200) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: got in_ready %b required 1 within 200 cycles", in_ready);
    end else if (push) begin
      push_exp(er, ef, ewb, eill, dst);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_nop = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_output: got result %h required no output", out_result);
      end else begin
        m_e = q.pop_front();
        chk($sformatf("pkt%0d_result", m_e.id), out_result, m_e.res);
        chk($sformatf("pkt%0d_flags", m_e.id), 64'(out_flags), 64'(m_e.flags));
        chk($sformatf("pkt%0d_wb_en", m_e.id), 64'(out_wb_en), 64'(m_e.wb));
        chk($sformatf("pkt%0d_illegal", m_e.id), 64'(out_illegal), 64'(m_e.ill));
        chk($sformatf("pkt%0d_dstreg", m_e.id), 64'(out_dstreg), 64'(m_e.dst));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish before 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_nop = 1'b0; in_flush = 1'b0; in_oper = '0;
    in_oper1 = '0; in_oper2 = '0; in_dstreg = '0; in_size = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_result", out_result, 64'd0);
    chk("rst_out_flags", 64'(out_flags), 64'd0);
    chk("rst_out_wb_en", 64'(out_wb_en), 64'd0);
    chk("rst_out_illegal", 64'(out_illegal), 64'd0);
    chk("rst_out_dstreg", 64'(out_dstreg), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // op, oper1, oper2, dst, size, nop, push, result, {OF,SF,ZF,CF}, wb, illegal
    send(8'h01, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 4'd1, 2'b11, 0, 1, 64'h0, 4'b0011, 1, 0);
    send(8'h01, 64'h1122_3344_5566_777F, 64'h01, 4'd2, 2'b00, 0, 1,
         64'h1122_3344_5566_7780, 4'b1100, 1, 0);
    send(8'h02, 64'hFFFF_FFFF_0000_0005, 64'h7, 4'd3, 2'b10, 0, 1,
         64'h0000_0000_FFFF_FFFE, 4'b0101, 1, 0);
    send(8'h07, 64'h1234, 64'h1234, 4'd4, 2'b11, 0, 1, 64'h1234, 4'b0010, 0, 0);
    send(8'h03, 64'hAAAA_0000_0000_F0F0, 64'h0FF0, 4'd5, 2'b01, 0, 1,
         64'hAAAA_0000_0000_00F0, 4'b0000, 1, 0);
    send(8'h05, 64'hDEAD_BEEF_8000_0001, 64'h1, 4'd6, 2'b10, 0, 1,
         64'h0000_0000_8000_0000, 4'b0100, 1, 0);
    send(8'h06, 64'h1111_1111_1111_1111, 64'hAB, 4'd7, 2'b00, 0, 1,
         64'h1111_1111_1111_11AB, 4'b0100, 1, 0);
    send(8'h04, 64'h00F0, 64'h000F, 4'd8, 2'b11, 0, 1, 64'hFF, 4'b0000, 1, 0);
    send(8'h08, 64'h81, 64'h1, 4'd9, 2'b00, 0, 1, 64'h02, 4'b0001, 1, 0);
    send(8'h08, 64'h5, 64'h40, 4'd10, 2'b11, 0, 1, 64'h5, 4'b0001, 1, 0);
    send(8'h09, 64'h8000_0000_0000_0001, 64'h2, 4'd11, 2'b11, 0, 1,
         64'h2000_0000_0000_0000, 4'b0000, 1, 0);
    send(8'h08, 64'hFF, 64'h8, 4'd12, 2'b00, 0, 1, 64'h0, 4'b0010, 1, 0);
    send(8'h33, 64'hCAFE, 64'h1, 4'd13, 2'b11, 0, 1, 64'hCAFE, 4'b0010, 0, 1);

    // 16-bit multiply: result appears W cycles after acceptance.
    send(8'h0A, 64'hFFFD, 64'h0007, 4'd14, 2'b01, 0, 1, 64'hFFEB, 4'b0100, 1, 0);
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(negedge clk);
      if (!out_valid) begin
        chk("imul16_in_ready_busy", 64'(in_ready), 64'd0);
        cyc++;
      end
    end
    chk("imul16_latency", 64'(cyc), 64'd16);
    @(posedge clk); #1;

    send(8'h0A, 64'h40, 64'h04, 4'd15, 2'b00, 0, 1, 64'h0, 4'b1011, 1, 0);
    send(8'h0A, 64'hFFFF_FFFF_FFFF_FFFE, 64'h3, 4'd1, 2'b11, 0, 1,
         64'hFFFF_FFFF_FFFF_FFFA, 4'b0100, 1, 0);
    send(8'h01, 64'h0, 64'h0, 4'd2, 2'b11, 1, 0, 64'h0, 4'b0000, 0, 0);
    repeat (80) @(posedge clk);
    #1;

    // Flush on the fifth cycle of a 64-bit multiply.
    send(8'h0A, 64'h7, 64'h9, 4'd3, 2'b11, 0, 0, 64'h0, 4'b0000, 0, 0);
    repeat (4) @(posedge clk);
    #1 in_flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready_low", 64'(in_ready), 64'd0);
    @(posedge clk); #1 in_flush = 1'b0;
    @(negedge clk);
    chk("flush_idle_ready", 64'(in_ready), 64'd1);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_flags_kept", 64'(out_flags), 64'(4'b0100));
    repeat (70) @(posedge clk);
    @(negedge clk);
    chk("flush_no_late_output", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    // Backpressure: first packet held while a second waits.
    out_ready = 1'b0;
    send(8'h01, 64'h1, 64'h2, 4'd3, 2'b11, 0, 1, 64'h3, 4'b0000, 1, 0);
    in_valid = 1'b1; in_oper = 8'h01; in_oper1 = 64'h7F; in_oper2 = 64'h1;
    in_dstreg = 4'd4; in_size = 2'b00;
    repeat (3) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_out_result", out_result, 64'h3);
      chk("bp_out_dstreg", 64'(out_dstreg), 64'd3);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    push_exp(64'h80, 4'b1100, 1'b1, 1'b0, 4'd4);
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a multiply.
    send(8'h0A, 64'h5, 64'h6, 4'd9, 2'b10, 0, 0, 64'h0, 4'b0000, 0, 0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_result", out_result, 64'd0);
    chk("arst_out_flags", 64'(out_flags), 64'd0);
    chk("arst_out_dstreg", 64'(out_dstreg), 64'd0);
    chk("arst_out_wb_en", 64'(out_wb_en), 64'd0);
    chk("arst_out_illegal", 64'(out_illegal), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1 reset = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("arst_no_late_output", 64'(out_valid), 64'd0);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage directly downstream of operand fetch.
- Consumes the decoded operation, both fetched operands, destination register index and operand size.
- Computes the ALU result and the CF/ZF/SF/OF flags, then presents a registered writeback packet to the writeback stage.
- Single-cycle ALU ops plus an iterative signed multiply, with valid/ready handshakes on both sides and a synchronous flush.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.
- OPW, 8, operation code width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  operand-fetch packet valid
- in_ready  out  1  stage can accept a packet
- in_nop  in  1  packet is a bubble: consumed, produces no output
- in_oper  in  8  operation code
- in_oper1  in  64  destination operand (full 64-bit register value)
- in_oper2  in  64  source operand (register, immediate or memory value)
- in_dstreg  in  4  destination register index
- in_size  in  2  operand size: 00=8, 01=16, 10=32, 11=64 bits (W)
- in_flush  in  1  synchronous pipeline flush
- out_valid  out  1  writeback packet valid
- out_ready  in  1  writeback stage accepts the packet
- out_wb_en  out  1  write out_result to out_dstreg
- out_dstreg  out  4  destination register index
- out_result  out  64  merged result
- out_flags  out  4  {OF,SF,ZF,CF}, architectural flags register
- out_illegal  out  1  unknown opcode

Behaviour:
- Reset (async): state=IDLE, out_valid=0, out_wb_en=0, out_dstreg=0, out_result=0, out_flags=0, out_illegal=0, counter=0.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !in_flush. Accept = in_valid && in_ready.
- Output register is single-entry. While out_valid=1 && out_ready=0, all out_* are held stable.
- States:
  - IDLE: accept of a non-MUL op loads the output register at that edge (latency 1), so out_valid=1 from the next cycle. Accept of IMUL goes to BUSY with counter=W.
  - BUSY: one multiplier bit per cycle; counter decrements. On the edge where counter goes 1->0, the output loads and the state returns to IDLE. out_valid rises W cycles after accept. in_ready=0 throughout BUSY.
- in_nop accepted: handshake completes, no output load, flags unchanged.
- Opcodes:
  - 01 ADD, 02 SUB, 03 AND, 04 OR, 05 XOR, 06 MOV, 07 CMP, 08 SHL, 09 SHR, 0A IMUL.
  - Any other opcode: out_illegal=1, out_wb_en=0, out_result=in_oper1, flags unchanged.
- Arithmetic on the low W bits, r=W-bit result.
  - ZF: r==0. SF: r[W-1].
  - ADD: CF=carry out of bit W-1; OF=signed overflow.
  - SUB/CMP: CF=borrow; OF=signed overflow.
  - AND/OR/XOR: CF=OF=0.
  - MOV: r=oper2; flags unchanged.
  - SHL/SHR: count = oper2[5:0] if W=64, else oper2[4:0]. Count 0: r=oper1, flags unchanged. Otherwise CF=last bit shifted out, OF=0. Count >= W gives r=0 and CF=0.
  - IMUL: sign-extend both operands from W bits, form magnitudes, shift-add over W cycles into a 2W-bit product, negate if the signs differ. r = low W bits. CF=OF=1 if the full product is not the sign-extension of r. ZF and SF are taken from r.
- Result merge:
  - W=8: {oper1[63:8], r}. W=16: {oper1[63:16], r}.
  - W=32: {32'b0, r}. W=64: r.
- out_wb_en=1 for all legal opcodes except CMP. For CMP, out_result=oper1 and flags are updated.
- out_flags is a register updated only when a packet loads the output register.
- in_flush: clears out_valid and returns BUSY to IDLE, discarding the partial product. It overrides acceptance in the same cycle. The flags register is unchanged.

Optional Feature:
- Macro EX_FAST_MUL_EN.
- Defined: IMUL is computed combinationally with a single-cycle latency identical to ADD; BUSY is unused.
- Undefined: iterative W-cycle multiply as specified above.
- Results and flags are bit-identical in both builds.

Test Plan:
- ADD W=64, oper1=FFFF_FFFF_FFFF_FFFF, oper2=1 -> next cycle out_result=0, ZF=1, CF=1, SF=0, OF=0, out_wb_en=1.
- ADD W=8, oper1=1122_3344_5566_777F, oper2=01 -> out_result=1122_3344_5566_7780, OF=1, SF=1, CF=0.
- SUB W=32, oper1=FFFF_FFFF_0000_0005, oper2=7 -> out_result=0000_0000_FFFF_FFFE, CF=1, SF=1. A following CMP with equal operands -> ZF=1, out_wb_en=0.
- IMUL W=16, oper1=FFFD (-3), oper2=0007 -> in_ready=0 for 16 cycles, then out_result low16=FFEB, CF=OF=0. IMUL W=8, 0x40*0x04 -> r=00, CF=OF=1.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_* stable and in_ready=0; an in_valid packet is accepted on the out_ready=1 cycle.
- Flush at cycle 5 of a W=64 IMUL -> next cycle state IDLE, out_valid=0, flags unchanged. Also assert reset mid-BUSY -> all outputs 0 immediately.
